// File: rtl/tmr_cfg_seq.sv
// Register-bus initiator that programs the 16-bit timer (count, period, control) and services its interrupts.
// Optional watchdog in WAIT_INT is enabled by defining TMR_CFG_SEQ_TIMEOUT_EN (adds the timeout output).
module tmr_cfg_seq #(
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        sys_clk,
    input  logic        sys_rstn,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] cfg_cnt,
    input  logic [15:0] cfg_prd,
    input  logic [15:0] cfg_con,
    input  logic [7:0]  num_evt,
    input  logic        tmr_int,
    output logic        tmr_cnt_wr,
    output logic        tmr_prd_wr,
    output logic        tmr_con_wr,
    output logic [15:0] icb_wdat,
    output logic        busy,
    output logic        done,
    output logic        aborted,
`ifdef TMR_CFG_SEQ_TIMEOUT_EN
    output logic        timeout,
`endif
    output logic [7:0]  evt_cnt
);

    typedef enum logic [3:0] {
        IDLE, WR_CNT, WR_PRD, WR_CON, GAP, WAIT_INT, REARM, STOP_WR, FIN
    } state_t;

    state_t      state, state_nx, ret, ret_nx, tgt;
    logic [3:0]  gap, gap_nx;
    logic [15:0] cnt_q, prd_q, con_q, cnt_nx, prd_nx, con_nx, wdat_nx;
    logic [7:0]  num_q, num_nx, evt_nx, evt_inc;
    logic        int_q, pend, pend_nx, int_edge, ev, abort, leave, aborted_nx;
`ifdef TMR_CFG_SEQ_TIMEOUT_EN
    logic [15:0] wd, wd_nx;
    logic        timeout_nx, tmo_hit;
`endif

    assign int_edge = tmr_int & ~int_q;

    always_comb begin
        state_nx   = state;
        ret_nx     = ret;
        gap_nx     = gap;
        cnt_nx     = cnt_q;
        prd_nx     = prd_q;
        con_nx     = con_q;
        num_nx     = num_q;
        pend_nx    = pend;
        evt_nx     = evt_cnt;
        aborted_nx = aborted;
        leave      = 1'b0;
        tgt        = IDLE;
        ev         = int_edge | pend;
        abort      = stop && !(state inside {IDLE, STOP_WR, FIN});
        evt_inc    = (evt_cnt == 8'hFF) ? evt_cnt : evt_cnt + 8'd1;
        wdat_nx    = icb_wdat;
`ifdef TMR_CFG_SEQ_TIMEOUT_EN
        wd_nx      = wd;
        timeout_nx = timeout;
        tmo_hit    = 1'b0;
`endif
        // Edges seen while not waiting are held (one deep) until WAIT_INT is entered
        if (state != IDLE && state != WAIT_INT && int_edge)
            pend_nx = 1'b1;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nx   = WR_CNT;
                    cnt_nx     = cfg_cnt;
                    prd_nx     = cfg_prd;
                    con_nx     = cfg_con;
                    num_nx     = num_evt;
                    evt_nx     = 8'd0;
                    aborted_nx = 1'b0;
                    pend_nx    = 1'b0;
`ifdef TMR_CFG_SEQ_TIMEOUT_EN
                    timeout_nx = 1'b0;
`endif
                end
            end
            WR_CNT: begin
                leave = 1'b1;
                tgt   = WR_PRD;
            end
            WR_PRD: begin
                leave = 1'b1;
                tgt   = WR_CON;
            end
            WR_CON, REARM: begin
                leave = 1'b1;
                tgt   = WAIT_INT;
            end
            GAP: begin
                if (gap == 4'd0) state_nx = ret;
                else             gap_nx   = gap - 4'd1;
            end
            WAIT_INT: begin
                pend_nx = 1'b0;
`ifdef TMR_CFG_SEQ_TIMEOUT_EN
                wd_nx = wd + 16'd1;
`endif
                if (ev) begin
                    evt_nx   = evt_inc;
                    state_nx = (num_q != 8'd0 && evt_inc == num_q) ? STOP_WR : REARM;
                end
`ifdef TMR_CFG_SEQ_TIMEOUT_EN
                else if (wd == 16'(TIMEOUT_CYC - 1)) begin
                    state_nx = STOP_WR;
                    tmo_hit  = 1'b1;
                end
`endif
            end
            STOP_WR: state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        if (leave) begin
            if (GAP_CYC == 0) begin
                state_nx = tgt;
            end else begin
                state_nx = GAP;
                ret_nx   = tgt;
                gap_nx   = 4'(GAP_CYC - 1);
            end
        end

        // Abort outranks any event or timeout seen in the same cycle
        if (abort) begin
            state_nx   = STOP_WR;
            aborted_nx = 1'b1;
            evt_nx     = evt_cnt;
        end
`ifdef TMR_CFG_SEQ_TIMEOUT_EN
        if (tmo_hit && !abort)
            timeout_nx = 1'b1;
        if (state_nx == WAIT_INT && state != WAIT_INT)
            wd_nx = 16'd0;
`endif

        case (state_nx)
            WR_CNT:          wdat_nx = cnt_nx;
            WR_PRD:          wdat_nx = prd_nx;
            WR_CON, REARM:   wdat_nx = con_nx;
            STOP_WR:         wdat_nx = 16'h0000;
            default:         wdat_nx = icb_wdat;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state      <= IDLE;
            ret        <= IDLE;
            gap        <= 4'd0;
            cnt_q      <= 16'd0;
            prd_q      <= 16'd0;
            con_q      <= 16'd0;
            num_q      <= 8'd0;
            int_q      <= 1'b0;
            pend       <= 1'b0;
            tmr_cnt_wr <= 1'b0;
            tmr_prd_wr <= 1'b0;
            tmr_con_wr <= 1'b0;
            icb_wdat   <= 16'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            evt_cnt    <= 8'd0;
`ifdef TMR_CFG_SEQ_TIMEOUT_EN
            wd         <= 16'd0;
            timeout    <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            ret        <= ret_nx;
            gap        <= gap_nx;
            cnt_q      <= cnt_nx;
            prd_q      <= prd_nx;
            con_q      <= con_nx;
            num_q      <= num_nx;
            int_q      <= tmr_int;
            pend       <= pend_nx;
            tmr_cnt_wr <= (state_nx == WR_CNT);
            tmr_prd_wr <= (state_nx == WR_PRD);
            tmr_con_wr <= (state_nx inside {WR_CON, REARM, STOP_WR});
            icb_wdat   <= wdat_nx;
            busy       <= (state_nx != IDLE);
            done       <= (state_nx == FIN);
            aborted    <= aborted_nx;
            evt_cnt    <= evt_nx;
`ifdef TMR_CFG_SEQ_TIMEOUT_EN
            wd         <= wd_nx;
            timeout    <= timeout_nx;
`endif
        end
    end

endmodule

// File: tb/tb_tmr_cfg_seq.sv
// Self-checking bench for tmr_cfg_seq: randomized runs checked against a write-list model of the timer programming rules.
// Covers the TMR_CFG_SEQ_TIMEOUT_EN build when that macro is defined.
module tb_tmr_cfg_seq;

    localparam int GAP = 2;
    localparam int TMO = 50;

    logic        sys_clk = 1'b0, sys_rstn = 1'b1, start = 1'b0, stop = 1'b0, tmr_int = 1'b0;
    logic [15:0] cfg_cnt = '0, cfg_prd = '0, cfg_con = '0;
    logic [7:0]  num_evt = '0;
    logic        tmr_cnt_wr, tmr_prd_wr, tmr_con_wr, busy, done, aborted;
    logic [15:0] icb_wdat;
    logic [7:0]  evt_cnt;
`ifdef TMR_CFG_SEQ_TIMEOUT_EN
    logic        timeout;
`endif

    tmr_cfg_seq #(.GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) dut (
        .sys_clk(sys_clk), .sys_rstn(sys_rstn), .start(start), .stop(stop),
        .cfg_cnt(cfg_cnt), .cfg_prd(cfg_prd), .cfg_con(cfg_con), .num_evt(num_evt),
        .tmr_int(tmr_int), .tmr_cnt_wr(tmr_cnt_wr), .tmr_prd_wr(tmr_prd_wr),
        .tmr_con_wr(tmr_con_wr), .icb_wdat(icb_wdat), .busy(busy), .done(done),
        .aborted(aborted),
`ifdef TMR_CFG_SEQ_TIMEOUT_EN
        .timeout(timeout),
`endif
        .evt_cnt(evt_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Write log: kind 0=cnt 1=prd 2=con, stamped with the edge index that samples the strobe
    int          wk[$];
    logic [15:0] wd[$];
    int          wc[$];
    int          done_n = 0, multi_n = 0;
    always @(posedge sys_clk) begin
        #1;
        if (tmr_cnt_wr) begin wk.push_back(0); wd.push_back(icb_wdat); wc.push_back(cyc + 1); end
        if (tmr_prd_wr) begin wk.push_back(1); wd.push_back(icb_wdat); wc.push_back(cyc + 1); end
        if (tmr_con_wr) begin wk.push_back(2); wd.push_back(icb_wdat); wc.push_back(cyc + 1); end
        if ($countones({tmr_cnt_wr, tmr_prd_wr, tmr_con_wr}) > 1) multi_n++;
        if (done) done_n++;
    end

    int          checks = 0, errors = 0;
    int          ek[$];
    logic [15:0] ed[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] c, p, n, input logic [7:0] ne, output int k);
        @(negedge sys_clk);
        cfg_cnt = c; cfg_prd = p; cfg_con = n; num_evt = ne; start = 1'b1;
        k = cyc + 1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    // Reference: three config writes, one con write per interrupt (0 on the last one), 0 on abort
    task automatic expectRun(input logic [15:0] c, p, n, input int nev, ints, input bit abrt);
        ek = {}; ed = {};
        ek.push_back(0); ed.push_back(c);
        ek.push_back(1); ed.push_back(p);
        ek.push_back(2); ed.push_back(n);
        for (int i = 1; i <= ints; i++) begin
            ek.push_back(2);
            ed.push_back((nev != 0 && i == nev) ? 16'h0000 : n);
        end
        if (abrt) begin ek.push_back(2); ed.push_back(16'h0000); end
    endtask

    task automatic checkRun(input string tag);
        checkOutput({tag, "_nwr"}, wk.size(), ek.size());
        for (int i = 0; i < ek.size() && i < wk.size(); i++) begin
            checkOutput($sformatf("%s_kind%0d", tag, i), wk[i], ek[i]);
            checkOutput($sformatf("%s_data%0d", tag, i), {16'h0, wd[i]}, {16'h0, ed[i]});
        end
        wk = {}; wd = {}; wc = {};
    endtask

    task automatic waitWrites(input int n, input int budget);
        int b = 0;
        while (wk.size() < n && b < budget) begin @(negedge sys_clk); b++; end
        checkOutput("wait_writes", (wk.size() >= n), 1);
    endtask

    task automatic waitIdle(input int budget);
        int b = 0;
        while (busy !== 1'b0 && b < budget) begin @(negedge sys_clk); b++; end
        checkOutput("wait_idle", busy, 0);
    endtask

    // Timer model: raise the interrupt, hold it until the next con write clears it
    task automatic serviceInt(input int dly);
        int n;
        repeat (dly) @(negedge sys_clk);
        n = wk.size();
        tmr_int = 1'b1;
        waitWrites(n + 1, 40);
        tmr_int = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int k, d0, ne;
        logic [15:0] c, p, n;

        #2 sys_rstn = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rstn = 1'b1;
        repeat (10) @(negedge sys_clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done_n", done_n, 0);
        checkOutput("rst_aborted", aborted, 0);
        checkOutput("rst_evt", evt_cnt, 0);
        checkOutput("rst_wdat", icb_wdat, 0);
        checkOutput("rst_strobes", {tmr_cnt_wr, tmr_prd_wr, tmr_con_wr}, 0);
        checkOutput("rst_nwr", wk.size(), 0);

        $display("[TB] directed config run");
        d0 = done_n;
        applyStimulus(16'h0000, 16'h0020, 16'h0001, 8'd2, k);
        checkOutput("cfg_busy", busy, 1);
        checkOutput("cfg_cnt_wr", tmr_cnt_wr, 1);
        waitWrites(3, 30);
        checkOutput("cfg_t_cnt", wc[0], k + 1);
        checkOutput("cfg_t_prd", wc[1], k + 4);
        checkOutput("cfg_t_con", wc[2], k + 7);
        serviceInt(3);
        serviceInt(3);
        waitIdle(30);
        checkOutput("cfg_done", done_n - d0, 1);
        checkOutput("cfg_evt", evt_cnt, 2);
        checkOutput("cfg_aborted", aborted, 0);
        checkOutput("cfg_wdat_hold", icb_wdat, 16'h0000);
        expectRun(16'h0000, 16'h0020, 16'h0001, 2, 2, 1'b0);
        checkRun("cfg");

        $display("[TB] random run with ignored start");
        c = 16'($urandom); p = 16'($urandom); n = 16'($urandom) | 16'h1;
        ne = $urandom_range(2, 4);
        d0 = done_n;
        applyStimulus(c, p, n, 8'(ne), k);
        waitWrites(3, 30);
        applyStimulus(~c, ~p, n ^ 16'h8000, 8'd1, k);
        for (int i = 0; i < ne; i++) serviceInt($urandom_range(1, 6));
        waitIdle(40);
        checkOutput("rnd_done", done_n - d0, 1);
        checkOutput("rnd_evt", evt_cnt, ne);
        expectRun(c, p, n, ne, ne, 1'b0);
        checkRun("rnd");

        $display("[TB] abort run");
        c = 16'($urandom); p = 16'($urandom); n = 16'($urandom) | 16'h1;
        d0 = done_n;
        applyStimulus(c, p, n, 8'd0, k);
        checkOutput("abt_aborted_clr", aborted, 0);
        waitWrites(3, 30);
        repeat (4) @(negedge sys_clk);
        tmr_int = 1'b1;
        repeat (5) @(negedge sys_clk);
        tmr_int = 1'b0;
        stop = 1'b1;
        @(negedge sys_clk);
        stop = 1'b0;
        waitIdle(30);
        checkOutput("abt_done", done_n - d0, 1);
        checkOutput("abt_aborted", aborted, 1);
        checkOutput("abt_evt", evt_cnt, 1);
        expectRun(c, p, n, 0, 1, 1'b1);
        checkRun("abt");

        $display("[TB] start and stop together in idle");
        d0 = done_n;
        @(negedge sys_clk);
        start = 1'b1; stop = 1'b1;
        @(negedge sys_clk);
        start = 1'b0; stop = 1'b0;
        repeat (5) @(negedge sys_clk);
        checkOutput("ss_nwr", wk.size(), 0);
        checkOutput("ss_busy", busy, 0);
        checkOutput("ss_done", done_n - d0, 0);
        checkOutput("ss_aborted_kept", aborted, 1);

        $display("[TB] saturating event count");
        c = 16'($urandom); p = 16'($urandom); n = 16'($urandom) | 16'h1;
        d0 = done_n;
        applyStimulus(c, p, n, 8'd0, k);
        waitWrites(3, 30);
        for (int i = 0; i < 257; i++) serviceInt($urandom_range(1, 3));
        repeat (2) @(negedge sys_clk);
        checkOutput("sat_evt", evt_cnt, 255);
        stop = 1'b1;
        @(negedge sys_clk);
        stop = 1'b0;
        waitIdle(30);
        checkOutput("sat_done", done_n - d0, 1);
        checkOutput("sat_aborted", aborted, 1);
        expectRun(c, p, n, 0, 257, 1'b1);
        checkRun("sat");

        $display("[TB] reset mid-run");
        d0 = done_n;
        applyStimulus(16'h1234, 16'h5678, 16'h0001, 8'd3, k);
        waitWrites(2, 30);
        @(negedge sys_clk);
        sys_rstn = 1'b0;
        #1;
        checkOutput("mrst_strobes", {tmr_cnt_wr, tmr_prd_wr, tmr_con_wr}, 0);
        checkOutput("mrst_busy", busy, 0);
        @(negedge sys_clk);
        sys_rstn = 1'b1;
        wk = {}; wd = {}; wc = {};
        repeat (10) @(negedge sys_clk);
        checkOutput("mrst_nwr", wk.size(), 0);
        checkOutput("mrst_done", done_n - d0, 0);

`ifdef TMR_CFG_SEQ_TIMEOUT_EN
        $display("[TB] watchdog timeout");
        c = 16'($urandom); p = 16'($urandom); n = 16'($urandom) | 16'h1;
        d0 = done_n;
        applyStimulus(c, p, n, 8'd0, k);
        waitWrites(4, 200);
        if (wk.size() >= 4) checkOutput("tmo_t", wc[3], wc[2] + GAP + 1 + TMO);
        waitIdle(20);
        checkOutput("tmo_flag", timeout, 1);
        checkOutput("tmo_aborted", aborted, 0);
        checkOutput("tmo_done", done_n - d0, 1);
        expectRun(c, p, n, 0, 0, 1'b1);
        checkRun("tmo");
`else
        $display("[TB] no watchdog: wait indefinitely");
        c = 16'($urandom); p = 16'($urandom); n = 16'($urandom) | 16'h1;
        applyStimulus(c, p, n, 8'd0, k);
        repeat (1000) @(negedge sys_clk);
        checkOutput("nowd_busy", busy, 1);
        checkOutput("nowd_nwr", wk.size(), 3);
        stop = 1'b1;
        @(negedge sys_clk);
        stop = 1'b0;
        waitIdle(20);
        checkOutput("nowd_aborted", aborted, 1);
        expectRun(c, p, n, 0, 0, 1'b1);
        checkRun("nowd");
`endif

        checkOutput("one_strobe", multi_n, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tmr_cfg_seq.md
Name: tmr_cfg_seq

Overview:
- Register-bus initiator that drives the 16-bit timer's write port (tmr_cnt_wr / tmr_prd_wr / tmr_con_wr + icb_wdat) and services its interrupt.
- On start, writes the count, period and control registers in order, then waits for interrupts. Each interrupt re-arms or stops the timer.
- Sits between the system controller and the timer, replacing software register pokes for N-event timing runs.

Parameters:
- GAP_CYC, 2, idle cycles between consecutive register writes (0 = back-to-back); legal range 0..15.
- TIMEOUT_CYC, 65535, max cycles in WAIT_INT before timeout (used only with the optional feature).

Ports:
- sys_clk  in  1  system clock, all logic on posedge
- sys_rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a run; sampled in IDLE only
- stop  in  1  one-cycle abort request
- cfg_cnt  in  16  initial count value, latched on accepted start
- cfg_prd  in  16  period value, latched on accepted start
- cfg_con  in  16  control value (bit0 = timer enable), latched on accepted start
- num_evt  in  8  interrupts to service before stopping; 0 = run until stop; latched on start
- tmr_int  in  1  timer interrupt (level, held until con write)
- tmr_cnt_wr  out  1  count-register write strobe
- tmr_prd_wr  out  1  period-register write strobe
- tmr_con_wr  out  1  control-register write strobe
- icb_wdat  out  16  write data, valid in the strobe cycle
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at run completion (normal, abort or timeout)
- aborted  out  1  sticky: last run ended by stop; cleared on next accepted start
- evt_cnt  out  8  interrupts serviced this run; cleared on accepted start, saturates at 255

Behaviour:
- Reset: all outputs 0; state IDLE; latched cfg regs 0; int edge register 0.
- All outputs are registered. At most one write strobe is high in any cycle. A strobe is high for exactly 1 cycle.
- icb_wdat holds its last written value between writes.
- State machine and transitions:
  - IDLE: start=1 and stop=0 -> latch cfg, clear evt_cnt/aborted -> WR_CNT. Start and stop together: stop wins, stay IDLE, no done.
  - WR_CNT: tmr_cnt_wr=1, icb_wdat=cfg_cnt -> GAP (then WR_PRD).
  - WR_PRD: tmr_prd_wr=1, icb_wdat=cfg_prd -> GAP (then WR_CON).
  - WR_CON: tmr_con_wr=1, icb_wdat=cfg_con -> GAP (then WAIT_INT).
  - GAP: counts GAP_CYC cycles with no strobe. With GAP_CYC=0 the state is skipped, so the next write is in the very next cycle.
  - WAIT_INT: rising edge of tmr_int (registered previous value) -> evt_cnt+1.
    - If num_evt!=0 and the new evt_cnt==num_evt -> STOP_WR.
    - Otherwise -> REARM.
  - REARM: tmr_con_wr=1, icb_wdat=cfg_con (clears the timer's int flag) -> GAP (then WAIT_INT).
  - STOP_WR: tmr_con_wr=1, icb_wdat=16'h0000 -> FIN.
  - FIN: done=1 for one cycle -> IDLE.
- Latency: start high at edge k -> tmr_cnt_wr high in cycle k+1. With GAP_CYC=2: tmr_prd_wr at k+4, tmr_con_wr at k+7.
- stop in any state except IDLE/STOP_WR/FIN: the current strobe (if any) completes this cycle, next state STOP_WR, aborted=1 set with the STOP_WR write.
- stop during STOP_WR/FIN is ignored.
- start while busy is ignored; the latched cfg is unchanged.
- A tmr_int edge arriving outside WAIT_INT (e.g. during GAP) is remembered (1-deep pending flag) and serviced on entry to WAIT_INT. A second edge while pending is dropped.
- evt_cnt saturates at 255 when num_evt=0.
- Async reset mid-run: immediate return to IDLE, strobes deassert, no STOP_WR issued.

Optional Feature:
- Macro: TMR_CFG_SEQ_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts cycles in WAIT_INT, cleared on every WAIT_INT entry.
  - When it reaches TIMEOUT_CYC: go to STOP_WR, set sticky output timeout (1 bit, cleared on accepted start), then done.
  - stop has priority over timeout in the same cycle (aborted=1, timeout=0).
- Undefined: no watchdog, no timeout port; WAIT_INT waits indefinitely.

Test Plan:
- Reset values: sys_rstn=0 then release -> all outputs 0, busy=0 for 10 cycles with start=0.
- Config sequence: GAP_CYC=2, start with cfg_cnt=16'h0000, cfg_prd=16'h0020, cfg_con=16'h0001, num_evt=2.
  - Expect 1-cycle strobes cnt/prd/con at k+1/k+4/k+7 with icb_wdat 0000/0020/0001.
  - busy=1 from k+1.
- Event count: same run, model tmr_int rising twice (cleared by each con write).
  - Expect REARM write 16'h0001 after the first interrupt.
  - Expect STOP_WR write 16'h0000 after the second, then done pulse; evt_cnt=2, aborted=0.
- Abort: num_evt=0, stop asserted 5 cycles after the first interrupt.
  - Expect con write 16'h0000, done=1, aborted=1, evt_cnt=1, then IDLE.
- Simultaneous/ignored requests:
  - start+stop together in IDLE -> no strobe, busy stays 0.
  - start during WAIT_INT -> latched cfg unchanged; later writes still use the original values.
- Timeout (macro defined, TIMEOUT_CYC=50, tmr_int held 0): con write 16'h0000 exactly 50 cycles after WAIT_INT entry, timeout=1, done pulse.
  - Macro undefined: still busy after 1000 cycles.
